// File: rtl/c64_bus_pkg.sv
// Shared types and constants for the C64 expansion-bus initiator.
package c64_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PORT_BITS  = 3;

  localparam logic [15:0] PORT_DDR_ADDR  = 16'h0000;
  localparam logic [15:0] PORT_DATA_ADDR = 16'h0001;

  localparam int unsigned LORAM  = 0;
  localparam int unsigned HIRAM  = 1;
  localparam int unsigned CHAREN = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_RISE,
    DRIVE,
    ACK
  } state_e;

  // Processor-port pin value: output bits follow data, input bits float high.
  function automatic logic [PORT_BITS-1:0] port_pins(input logic [PORT_BITS-1:0] ddr,
                                                     input logic [PORT_BITS-1:0] pdata);
    logic [PORT_BITS-1:0] pins;
    for (int unsigned i = 0; i < PORT_BITS; i++) begin
      pins[i] = ddr[i] ? pdata[i] : 1'b1;
    end
    return pins;
  endfunction

endpackage

// File: rtl/c64_bus_initiator_if.sv
// Request/acknowledge handshake between the fast CPU side and the bus initiator.
interface c64_bus_initiator_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              req;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              ack;
  logic [7:0]        rd_data;
  logic              busy;

  modport master (
    output req, req_rw, req_addr, req_wdata,
    input  ack, rd_data, busy
  );

  modport slave (
    input  req, req_rw, req_addr, req_wdata,
    output ack, rd_data, busy
  );
endinterface

// File: rtl/c64_phi_sync.sv
// N-stage synchroniser for an asynchronous C64 signal with edge detect.
module c64_phi_sync #(
  parameter int unsigned N       = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  // sh_q[N-1] is the synchronised level, sh_q[N] the previous synced sample.
  logic [N:0] sh_q;
  logic [N:0] sh_d;

  // Shift the raw input through the chain.
  always_comb begin
    sh_d = {sh_q[N-1:0], d};
  end

  // Synchroniser flops.
  always_ff @(posedge clk) begin
    if (!rst_n) sh_q <= {(N + 1){RST_VAL}};
    else        sh_q <= sh_d;
  end

  assign level  = sh_q[N-1];
  assign rise_c =  sh_q[N-1] & ~sh_q[N];
  assign fall_c = ~sh_q[N-1] &  sh_q[N];

endmodule

// File: rtl/c64_bus_initiator.sv
// Runs one C64 expansion-bus cycle per request and shadows the 6510 processor port.
module c64_bus_initiator
  import c64_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      _reset,
  c64_bus_initiator_if.slave        rq,
  input  logic                      phi0,
  input  logic                      c64_rdy,
  input  logic [DATA_W-1:0]         bus_din,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_dout,
  output logic                      bus_r_w,
  output logic                      bus_oe,
  output logic                      bus_doe,
  output logic                      _loram,
  output logic                      _hiram,
  output logic                      _charen
);

  localparam int unsigned DL_DEPTH = SYNC_STAGES + 1;

  state_e state_q, state_d;

  logic phi0_s, phi0_rise_c, phi0_fall_c;
  logic rdy_s, rdy_rise_unused, rdy_fall_unused;

  logic [DL_DEPTH-1:0][DATA_W-1:0] din_dl_q, din_dl_d;
  logic [DL_DEPTH-1:0]             rdy_dl_q, rdy_dl_d;
  logic [DATA_W-1:0]               din_old_c;
  logic                            rdy_old_c;
  logic                            retry_c;

  logic [ADDR_W-1:0]    bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]    bus_dout_q, bus_dout_d;
  logic                 rw_q, rw_d;
  logic                 bus_r_w_q, bus_r_w_d;
  logic                 bus_oe_q, bus_oe_d;
  logic                 bus_doe_q, bus_doe_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic [DATA_W-1:0]    ddr_q, ddr_d;
  logic [DATA_W-1:0]    pdata_q, pdata_d;
  logic [PORT_BITS-1:0] pport_q, pport_d;

  c64_phi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_phi0_sync (
    .clk    (clk),
    .rst_n  (_reset),
    .d      (phi0),
    .level  (phi0_s),
    .rise_c (phi0_rise_c),
    .fall_c (phi0_fall_c)
  );

  c64_phi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_rdy_sync (
    .clk    (clk),
    .rst_n  (_reset),
    .d      (c64_rdy),
    .level  (rdy_s),
    .rise_c (rdy_rise_unused),
    .fall_c (rdy_fall_unused)
  );

  // Delay line aligning bus data and rdy with the synchronised phi0 fall.
  always_comb begin
    din_dl_d  = {din_dl_q[DL_DEPTH-2:0], bus_din};
    rdy_dl_d  = {rdy_dl_q[DL_DEPTH-2:0], rdy_s};
    din_old_c = din_dl_q[DL_DEPTH-1];
    rdy_old_c = rdy_dl_q[DL_DEPTH-1];
    retry_c   = rw_q & ~rdy_old_c;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (rq.req)      state_d = ARM;
      ARM:       if (!phi0_s)     state_d = WAIT_RISE;
      WAIT_RISE: if (phi0_rise_c) state_d = DRIVE;
      DRIVE:     if (phi0_fall_c) state_d = retry_c ? ARM : ACK;
      ACK:                        state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output/datapath next values; everything below lands in a flop.
  always_comb begin
    bus_addr_d = bus_addr_q;
    bus_dout_d = bus_dout_q;
    rw_d       = rw_q;
    bus_r_w_d  = bus_r_w_q;
    bus_oe_d   = bus_oe_q;
    bus_doe_d  = bus_doe_q;
    ack_d      = 1'b0;
    rd_data_d  = rd_data_q;
    ddr_d      = ddr_q;
    pdata_d    = pdata_q;
    case (state_q)
      IDLE: begin
        if (rq.req) begin
          bus_addr_d = rq.req_addr;
          bus_dout_d = rq.req_wdata;
          rw_d       = rq.req_rw;
        end
      end
      WAIT_RISE: begin
        if (phi0_rise_c) begin
          bus_oe_d  = 1'b1;
          bus_r_w_d = rw_q;
          bus_doe_d = ~rw_q;
        end
      end
      DRIVE: begin
        if (phi0_fall_c) begin
          bus_oe_d  = 1'b0;
          bus_doe_d = 1'b0;
          bus_r_w_d = 1'b1;
          if (!retry_c) begin
            ack_d = 1'b1;
            if (rw_q) rd_data_d = din_old_c;
          end
        end
      end
      ACK: begin
        if (!rw_q) begin
          if (bus_addr_q == ADDR_W'(PORT_DDR_ADDR))  ddr_d   = bus_dout_q;
          if (bus_addr_q == ADDR_W'(PORT_DATA_ADDR)) pdata_d = bus_dout_q;
        end
      end
      default: ;
    endcase
    busy_d  = (state_d != IDLE);
    pport_d = port_pins(ddr_d[PORT_BITS-1:0], pdata_d[PORT_BITS-1:0]);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      din_dl_q   <= '0;
      rdy_dl_q   <= '1;
      bus_addr_q <= '0;
      bus_dout_q <= '0;
      rw_q       <= 1'b1;
      bus_r_w_q  <= 1'b1;
      bus_oe_q   <= 1'b0;
      bus_doe_q  <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      rd_data_q  <= '0;
      ddr_q      <= '0;
      pdata_q    <= '0;
      pport_q    <= '1;
    end else begin
      din_dl_q   <= din_dl_d;
      rdy_dl_q   <= rdy_dl_d;
      bus_addr_q <= bus_addr_d;
      bus_dout_q <= bus_dout_d;
      rw_q       <= rw_d;
      bus_r_w_q  <= bus_r_w_d;
      bus_oe_q   <= bus_oe_d;
      bus_doe_q  <= bus_doe_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      ddr_q      <= ddr_d;
      pdata_q    <= pdata_d;
      pport_q    <= pport_d;
    end
  end

  assign bus_addr   = bus_addr_q;
  assign bus_dout   = bus_dout_q;
  assign bus_r_w    = bus_r_w_q;
  assign bus_oe     = bus_oe_q;
  assign bus_doe    = bus_doe_q;
  assign rq.ack     = ack_q;
  assign rq.rd_data = rd_data_q;
  assign rq.busy    = busy_q;
  assign _loram     = pport_q[LORAM];
  assign _hiram     = pport_q[HIRAM];
  assign _charen    = pport_q[CHAREN];

endmodule

// File: tb/tb_c64_bus_initiator.sv
// Scoreboard bench: C64 memory model on the bus side, reference memory/port model on the request side.
module tb_c64_bus_initiator;

  localparam int unsigned AW        = 16;
  localparam int          NSLOT     = 8;
  localparam int          ACK_BOUND = 3000;

  typedef struct packed {
    logic       rw;
    logic [7:0] rd;
    logic [2:0] port;
  } exp_t;

  logic          clk     = 1'b0;
  logic          _reset  = 1'b0;
  logic          phi0    = 1'b0;
  logic          c64_rdy = 1'b1;
  logic [7:0]    bus_din;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_dout;
  logic          bus_r_w, bus_oe, bus_doe;
  logic          _loram, _hiram, _charen;

  c64_bus_initiator_if #(.ADDR_W(AW)) rq_if ();

  c64_bus_initiator #(.SYNC_STAGES(2), .ADDR_W(AW)) dut (
    .clk      (clk),
    ._reset   (_reset),
    .rq       (rq_if),
    .phi0     (phi0),
    .c64_rdy  (c64_rdy),
    .bus_din  (bus_din),
    .bus_addr (bus_addr),
    .bus_dout (bus_dout),
    .bus_r_w  (bus_r_w),
    .bus_oe   (bus_oe),
    .bus_doe  (bus_doe),
    ._loram   (_loram),
    ._hiram   (_hiram),
    ._charen  (_charen)
  );

  always #5 clk = ~clk;

  // phi0 is 20 clk periods, phase-offset from clk.
  initial begin
    #3;
    forever #100 phi0 = ~phi0;
  end

  logic [15:0] addr_tab [NSLOT] = '{16'h0000, 16'h0001, 16'hD020, 16'hD012,
                                    16'h0400, 16'hC000, 16'h8000, 16'hFFFE};
  logic [7:0]  bus_mem [NSLOT];
  logic [7:0]  ref_mem [NSLOT];
  logic [7:0]  m_ddr   = 8'h00;
  logic [7:0]  m_pdata = 8'h00;
  logic [7:0]  noise   = 8'h00;

  exp_t sb_q[$];
  int   checks = 0, failures = 0;
  int   issued = 0, acks = 0, drives = 0;
  int   rdy_mode = 0, rdy_lows_left = 0;

  logic        cur_rw = 1'b1;
  logic [15:0] cur_addr = 16'h0;
  logic [7:0]  cur_wdata = 8'h0;

  function automatic int slot_of(input logic [15:0] a);
    for (int i = 0; i < NSLOT; i++) if (addr_tab[i] == a) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // C64 side: memory that answers reads (inverted data while RDY is low) and absorbs writes.
  always_comb begin
    if (bus_oe && bus_r_w) bus_din = c64_rdy ? bus_mem[slot_of(bus_addr)] : ~bus_mem[slot_of(bus_addr)];
    else                   bus_din = noise;
  end

  initial begin : bus_slave
    forever begin
      @(posedge phi0);
      noise = 8'($urandom);
      case (rdy_mode)
        1:       c64_rdy = ($urandom_range(3) != 0);
        2: begin
          if (rdy_lows_left > 0) begin
            c64_rdy = 1'b0;
            rdy_lows_left--;
          end else c64_rdy = 1'b1;
        end
        default: c64_rdy = 1'b1;
      endcase
      @(negedge phi0);
      if (bus_oe) begin
        drives++;
        chk("bus_addr", 32'(bus_addr), 32'(cur_addr));
        chk("bus_r_w", 32'(bus_r_w), 32'(cur_rw));
        chk("bus_doe", 32'(bus_doe), 32'(!cur_rw));
        if (!cur_rw) chk("bus_dout", 32'(bus_dout), 32'(cur_wdata));
        if (bus_doe) bus_mem[slot_of(bus_addr)] = bus_dout;
      end
      #50;
      chk("lowphase_idle", 32'(bus_oe), 32'd0);
    end
  end

  // Monitor: every ack pops one expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rq_if.ack === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", 32'(rq_if.ack), 32'd0);
        end else begin
          e = sb_q.pop_front();
          acks++;
          if (e.rw) chk("rd_data", 32'(rq_if.rd_data), 32'(e.rd));
          chk("ack_bus_released", 32'({bus_oe, bus_doe, bus_r_w}), 32'b001);
          @(negedge clk);
          chk("ack_one_clk", 32'(rq_if.ack), 32'd0);
          @(negedge clk);
          chk("port_pins", 32'({_charen, _hiram, _loram}), 32'(e.port));
        end
      end
    end
  end

  task automatic issue(input logic rw, input logic [15:0] addr, input logic [7:0] wdata, input bit push);
    exp_t e;
    int   s;
    s = slot_of(addr);
    if (push) begin
      if (!rw) begin
        ref_mem[s] = wdata;
        if (addr == 16'h0000) m_ddr   = wdata;
        if (addr == 16'h0001) m_pdata = wdata;
      end
      e.rw   = rw;
      e.rd   = rw ? ref_mem[s] : 8'h00;
      e.port = ~m_ddr[2:0] | m_pdata[2:0];
      sb_q.push_back(e);
      issued++;
    end
    cur_rw    = rw;
    cur_addr  = addr;
    cur_wdata = wdata;
    rq_if.req_rw    = rw;
    rq_if.req_addr  = addr;
    rq_if.req_wdata = wdata;
    rq_if.req       = 1'b1;
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < ACK_BOUND; i++) begin
      @(negedge clk);
      if (rq_if.ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: no ack within %0d clks at %0t", ACK_BOUND, $time);
      sb_q.delete();
      rq_if.req = 1'b0;
    end
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bit          got;
    int          d0, s;
    logic        rw;
    logic [7:0]  wd;

    rq_if.req = 1'b0; rq_if.req_rw = 1'b1; rq_if.req_addr = '0; rq_if.req_wdata = '0;
    for (int i = 0; i < NSLOT; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(rq_if.ack), 32'd0);
    chk("rst_busy", 32'(rq_if.busy), 32'd0);
    chk("rst_bus_oe", 32'(bus_oe), 32'd0);
    chk("rst_bus_doe", 32'(bus_doe), 32'd0);
    chk("rst_bus_r_w", 32'(bus_r_w), 32'd1);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    chk("rst_rd_data", 32'(rq_if.rd_data), 32'd0);
    chk("rst_port", 32'({_charen, _hiram, _loram}), 32'b111);
    _reset = 1'b1;
    repeat (5) @(negedge clk);

    // Simple read of $D020.
    bus_mem[slot_of(16'hD020)] = 8'h0E;
    ref_mem[slot_of(16'hD020)] = 8'h0E;
    d0 = drives;
    issue(1'b1, 16'hD020, 8'h00, 1'b1);
    @(negedge clk);
    chk("busy_after_req", 32'(rq_if.busy), 32'd1);
    wait_ack(got);
    rq_if.req = 1'b0;
    chk("read_d020_data", 32'(rq_if.rd_data), 32'h0E);
    chk("read_d020_drives", 32'(drives - d0), 32'd1);
    repeat (10) @(negedge clk);

    // Processor-port writes.
    issue(1'b0, 16'h0000, 8'h2F, 1'b1);
    wait_ack(got);
    rq_if.req = 1'b0;
    repeat (7) @(negedge clk);
    issue(1'b0, 16'h0001, 8'h35, 1'b1);
    wait_ack(got);
    rq_if.req = 1'b0;
    repeat (3) @(negedge clk);
    chk("port_after_2f_35", 32'({_charen, _hiram, _loram}), 32'b101);

    // Read held off by RDY for three phi0 cycles.
    rdy_mode = 2;
    bus_mem[slot_of(16'hD012)] = 8'h5A;
    ref_mem[slot_of(16'hD012)] = 8'h5A;
    @(negedge phi0);
    rdy_lows_left = 3;
    d0 = drives;
    issue(1'b1, 16'hD012, 8'h00, 1'b1);
    wait_ack(got);
    rq_if.req = 1'b0;
    chk("rdy_retry_drives", 32'(drives - d0), 32'd4);
    chk("rdy_retry_data", 32'(rq_if.rd_data), 32'h5A);
    rdy_mode = 0;
    repeat (10) @(negedge clk);

    // Request raised part-way through phi2-high.
    @(posedge phi0);
    repeat (5) @(negedge clk);
    d0 = drives;
    issue(1'b1, 16'hC000, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    chk("late_req_no_partial", 32'(bus_oe), 32'd0);
    wait_ack(got);
    rq_if.req = 1'b0;
    chk("late_req_drives", 32'(drives - d0), 32'd1);
    repeat (10) @(negedge clk);

    // Randomised traffic with random RDY and back-to-back requests.
    rdy_mode = 1;
    for (int n = 0; n < 60; n++) begin
      s  = $urandom_range(NSLOT - 1);
      rw = 1'($urandom_range(1));
      wd = 8'($urandom);
      issue(rw, addr_tab[s], wd, 1'b1);
      wait_ack(got);
      if (!got || $urandom_range(2) == 0) begin
        rq_if.req = 1'b0;
        repeat ($urandom_range(1, 25)) @(negedge clk);
      end
    end
    rq_if.req = 1'b0;
    rdy_mode = 0;
    repeat (10) @(negedge clk);

    // Reset during a processor-port write drops the write.
    issue(1'b0, 16'h0000, 8'h07, 1'b1);
    wait_ack(got);
    rq_if.req = 1'b0;
    repeat (5) @(negedge clk);
    issue(1'b0, 16'h0001, 8'h00, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_oe) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_mid_reached_drive", 32'(got), 32'd1);
    _reset    = 1'b0;
    rq_if.req = 1'b0;
    @(negedge clk);
    chk("rst_mid_bus_oe", 32'(bus_oe), 32'd0);
    chk("rst_mid_bus_doe", 32'(bus_doe), 32'd0);
    chk("rst_mid_bus_r_w", 32'(bus_r_w), 32'd1);
    chk("rst_mid_ack", 32'(rq_if.ack), 32'd0);
    chk("rst_mid_port", 32'({_charen, _hiram, _loram}), 32'b111);
    chk("rst_mid_rd_data", 32'(rq_if.rd_data), 32'd0);
    _reset  = 1'b1;
    m_ddr   = 8'h00;
    m_pdata = 8'h00;
    repeat (40) @(negedge clk);

    // Recovery read after reset.
    issue(1'b1, 16'hD020, 8'h00, 1'b1);
    wait_ack(got);
    rq_if.req = 1'b0;
    repeat (10) @(negedge clk);

    chk("ack_count", 32'(acks), 32'(issued));
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
